mod21_residue_norm: RTL and testbench

- Streaming normaliser that sits directly downstream of the mod-21 carry-save reducer.
- It takes the reducer's 7-bit partial residue, which is congruent to n mod 21 and nominally 0..70, and produces the canonical residue 0..20.
- It is a 2-stage pipeline with a valid/ready handshake, an out-of-contract flag and a saturating delivery counter.
- It feeds the RNS channel registers and the later reverse-conversion logic.

---
 rtl/mod21_residue_norm.sv | 125 ++++++++++++
 tb/tb_mod21_residue_norm.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mod21_residue_norm.sv
// Two-stage streaming normaliser for the mod-21 carry-save reducer.
// It folds the 7-bit partial residue (nominally 0..70, congruent to n mod 21)
// down to the canonical residue 0..20.
// Stage 1 removes a multiple of 63 and flags out-of-range inputs.
// Stage 2 removes 42 and then 21.
// A saturating counter tracks how many results have been delivered downstream.
module mod21_residue_norm #(
    parameter int CNT_W  = 16,
    parameter int MAX_IN = 70
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_final,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_res,
    output logic             out_err,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [6:0]       MAX_IN_W = 7'(MAX_IN);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // Stage 1 registers: folded value and out-of-contract flag.
    logic       s1_valid_q, s1_valid_d;
    logic [6:0] s1_y_q,     s1_y_d;
    logic       s1_e_q,     s1_e_d;

    // Stage 2 registers drive the outputs directly.
    logic       s2_valid_q, s2_valid_d;
    logic [4:0] out_res_q,  out_res_d;
    logic       out_err_q,  out_err_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       s1_load;
    logic       s2_load;
    logic       out_xfer;
    logic [6:0] y_calc;
    logic [6:0] z_calc;
    logic [4:0] r_calc;

    // Handshake: stage 2 takes stage 1 whenever it is empty or draining.
    // in_ready looks through to out_ready on purpose; there is no skid buffer.
    always_comb begin
        s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
        in_ready = ~s1_valid_q | s2_load;
        s1_load  = in_valid & in_ready;
        out_xfer = s2_valid_q & out_ready;
    end

    // Residue arithmetic. 63 and 42 are both multiples of 21. Each subtraction
    // is guarded by its compare, so the unsigned result never borrows.
    always_comb begin
        y_calc = (in_final >= 7'd63) ? in_final - 7'd63 : in_final;
        z_calc = (s1_y_q >= 7'd42) ? s1_y_q - 7'd42 : s1_y_q;
        r_calc = (z_calc >= 7'd21) ? 5'(z_calc - 7'd21) : z_calc[4:0];
    end

    // Next-state for both stages and the delivery counter.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        s1_valid_d = s1_valid_q;
        s1_y_d     = s1_y_q;
        s1_e_d     = s1_e_q;
        s2_valid_d = s2_valid_q;
        out_res_d  = out_res_q;
        out_err_d  = out_err_q;
        cnt_d      = cnt_q;

        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_y_d     = y_calc;
            s1_e_d     = (in_final > MAX_IN_W);
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            s2_valid_d = 1'b1;
            out_res_d  = r_calc;
            out_err_d  = s1_e_q;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end

        // A clear wins over a coincident delivery.
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_xfer && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Pipeline and counter state. Reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_y_q     <= '0;
            s1_e_q     <= 1'b0;
            s2_valid_q <= 1'b0;
            out_res_q  <= '0;
            out_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            s1_valid_q <= s1_valid_d;
            s1_y_q     <= s1_y_d;
            s1_e_q     <= s1_e_d;
            s2_valid_q <= s2_valid_d;
            out_res_q  <= out_res_d;
            out_err_q  <= out_err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_res   = out_res_q;
    assign out_err   = out_err_q;
    assign cnt       = cnt_q;

endmodule

// File: tb/tb_mod21_residue_norm.sv
// Directed and randomised bench for mod21_residue_norm.
// A scoreboard queue receives the expected residue and error flag at each
// input transfer. Each output transfer pops the queue and compares.
module tb_mod21_residue_norm;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       in_final;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       out_res;
    logic             out_err;
    logic             cnt_clr;
    logic [CNT_W-1:0] cnt;

    typedef struct packed {
        logic [4:0] res;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mod21_residue_norm #(.CNT_W(CNT_W), .MAX_IN(70)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_final  (in_final),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_err   (out_err),
        .cnt_clr   (cnt_clr),
        .cnt       (cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [6:0] x);
        exp_t e;
        e.res = 5'(int'(x) % 21);
        e.err = (int'(x) > 70);
        return e;
    endfunction

    // Scoreboard: pop and compare on output transfer, push on input transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_res", 32'(out_res), 32'(e.res));
                    check("out_err", 32'(out_err), 32'(e.err));
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_final));
        end
    end

    // Offer v until it is accepted. in_valid stays high afterwards.
    task automatic send(input logic [6:0] v);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_final = v;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    // Let everything in flight drain out, within a bounded number of cycles.
    task automatic drain();
        bit done;
        done      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #3;
            if (sb.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        check("drain_done", 32'(done), 32'd1);
    endtask

    initial begin
        logic [6:0] seq1 [6];
        int idx;
        seq1 = '{7'd0, 7'd20, 7'd21, 7'd42, 7'd63, 7'd70};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_final  = '0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_res", 32'(out_res), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_cnt", 32'(cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back legal inputs. The first out_valid appears two cycles after the first transfer.
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_final = seq1[i];
            @(negedge clk);
            check("b2b_in_ready", 32'(in_ready), 32'd1);
            check("b2b_out_valid", 32'(out_valid), (i >= 2) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
        drain();
        check("cnt_after_6", 32'(cnt), 32'd6);

        // Out-of-contract inputs still reduce correctly and raise out_err.
        send(7'd71);
        send(7'd126);
        send(7'd127);
        drain();
        check("cnt_after_9", 32'(cnt), 32'd9);

        // All 128 codes with random in_valid and out_ready.
        idx = 0;
        for (int k = 0; k < 5000 && idx < 128; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_final  = 7'(idx);
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #1;
        end
        check("sweep_all_sent", 32'(idx), 32'd128);
        drain();
        check("cnt_saturated_sweep", 32'(cnt), 32'd15);

        // Back-pressure: hold two items, in_ready low, output stable.
        out_ready = 1'b0;
        send(7'd5);
        send(7'd30);
        in_final = 7'd50;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_res", 32'(out_res), 32'd5);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(7'd50);
        drain();

        // Reset mid-operation with two items in flight.
        out_ready = 1'b0;
        send(7'd10);
        send(7'd11);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_cnt", 32'(cnt), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(7'd64);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_res", 32'(out_res), 32'd1);
        drain();

        // Counter saturation and clear priority.
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check("cnt_cleared", 32'(cnt), 32'd0);
        for (int i = 0; i < 17; i++) send(7'(i * 3));
        drain();
        check("cnt_sat_17", 32'(cnt), 32'd15);
        send(7'd3);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        cnt_clr = 1'b1;
        @(negedge clk);
        check("clr_coincident_xfer", 32'(out_valid && out_ready), 32'd1);
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check("cnt_clr_priority", 32'(cnt), 32'd0);
        drain();
        check("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
